mul24_share_arbiter: RTL

//  Shares one multiplier_24bit mantissa multiplier between two requesters (FP multiply

---
 rtl/mul24_share_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mul24_share_arbiter.sv
// mul24_share_arbiter
//   Shares one external mantissa multiplier between two requesters.
//   Port 0 is the FP multiply path and port 1 is the divide/normalise path.
//   Operand pairs arrive over valid/ready. A round-robin grant picks one of them.
//   The operands are registered onto mul_m/mul_q, and the design waits MUL_LAT cycles.
//   It then captures mul_r and returns the full 2N-bit product to the owner over valid/ready.
//   Only one operation is in flight at a time.
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   req{0,1}_valid/ready/a/b  operand request channels (ready is combinational)
//   rsp{0,1}_valid/ready      response channels; both share rsp_prod
//   rsp_prod                  registered 2N-bit product
//   mul_m, mul_q, mul_r       registered multiplier operands, multiplier result
//   busy                      high while an operation is in WAIT or RESP
module mul24_share_arbiter #(
  parameter int unsigned N       = 24,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [2*N-1:0]   rsp_prod,
  output logic [N-1:0]     mul_m,
  output logic [N-1:0]     mul_q,
  input  logic [2*N-1:0]   mul_r,
  output logic             busy
);

  localparam int unsigned P_W   = 2 * N;
  localparam int unsigned CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic             owner, owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N-1:0]     mul_m_nxt, mul_q_nxt;
  logic [P_W-1:0]   rsp_prod_nxt;
  logic             rsp0_valid_nxt, rsp1_valid_nxt, busy_nxt;
  logic             grant_c, accept_c, rsp_take_c;

  // Round-robin grant: a lone requester wins; when both are valid, the one not served last wins
  always_comb begin
    grant_c = ~last_grant;
    if (req0_valid && !req1_valid)
      grant_c = 1'b0;
    else if (req1_valid && !req0_valid)
      grant_c = 1'b1;
  end

  // Request handshake is only offered in IDLE, and only to the granted port
  assign req0_ready = (state == S_IDLE) && !grant_c && req0_valid;
  assign req1_ready = (state == S_IDLE) &&  grant_c && req1_valid;
  assign accept_c   = req0_ready || req1_ready;

  // Only the owner's response ready can complete the operation
  assign rsp_take_c = owner ? rsp1_ready : rsp0_ready;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    cnt_nxt        = cnt;
    mul_m_nxt      = mul_m;
    mul_q_nxt      = mul_q;
    rsp_prod_nxt   = rsp_prod;
    rsp0_valid_nxt = rsp0_valid;
    rsp1_valid_nxt = rsp1_valid;
    busy_nxt       = busy;

    case (state)
      S_IDLE: begin
        if (accept_c) begin
          mul_m_nxt = grant_c ? req1_a : req0_a;
          mul_q_nxt = grant_c ? req1_b : req0_b;
          owner_nxt = grant_c;
          cnt_nxt   = CNT_W'(MUL_LAT);
          busy_nxt  = 1'b1;
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          rsp_prod_nxt   = mul_r;
          rsp0_valid_nxt = ~owner;
          rsp1_valid_nxt = owner;
          state_nxt      = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_take_c) begin
          last_grant_nxt = owner;
          rsp0_valid_nxt = 1'b0;
          rsp1_valid_nxt = 1'b0;
          busy_nxt       = 1'b0;
          state_nxt      = S_IDLE;
        end
      end

      default: begin
        rsp0_valid_nxt = 1'b0;
        rsp1_valid_nxt = 1'b0;
        busy_nxt       = 1'b0;
        state_nxt      = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers; mul_m/mul_q hold their values between operations
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      mul_m      <= '0;
      mul_q      <= '0;
      rsp_prod   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      cnt        <= cnt_nxt;
      mul_m      <= mul_m_nxt;
      mul_q      <= mul_q_nxt;
      rsp_prod   <= rsp_prod_nxt;
      rsp0_valid <= rsp0_valid_nxt;
      rsp1_valid <= rsp1_valid_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
